// File: rtl/param_stack_pkg.sv
//==============================================================================
// Module      : param_stack_pkg
// Description : Shared definitions for the return-address stack: program
//               counter width and the stack command encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package param_stack_pkg;

    localparam int c_PC_WIDTH = 11;

    typedef enum logic [1:0] {
        c_STK_NOP     = 2'b00,
        c_STK_PUSH    = 2'b01,
        c_STK_POP     = 2'b10,
        c_STK_REPLACE = 2'b11
    } stk_cmd_e;

endpackage

`default_nettype wire

// File: rtl/param_stack_file.sv
//==============================================================================
// Module      : param_stack_file
// Description : DEPTH x WIDTH frame storage with one write port, one
//               asynchronous read port and a synchronous active-low clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module param_stack_file #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_frame_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        logic w_row_we;
        assign w_row_we = i_we && (i_waddr == AW'(gi));

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_frame_q[gi] <= '0;
            end else if (w_row_we) begin
                r_frame_q[gi] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_frame_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/param_stack.sv
//==============================================================================
// Module      : param_stack
// Description : Parametrised return-address stack with replace command,
//               occupancy status and wrap/saturate overflow policy.
//               Sticky error flags are built only when STACK_ERR_FLAGS_EN
//               is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH = c_PC_WIDTH,
    parameter int DEPTH = 2,
    parameter int WRAP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               commandIn,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         topOut,
    output logic [$clog2(DEPTH):0]   countOut,
    output logic                     fullOut,
    output logic                     emptyOut,
    input  logic                     errClrIn,
    output logic                     overflowOut,
    output logic                     underflowOut
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [c_AW-1:0] r_ptr_q,   w_ptr_d;
    logic [c_CW-1:0] r_count_q, w_count_d;
    logic [c_AW-1:0] w_top_idx;
    logic [c_AW-1:0] w_waddr;
    logic            w_we;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ovf;
    logic            w_pop_unf;

    assign w_full    = (r_count_q == c_CW'(DEPTH));
    assign w_empty   = (r_count_q == '0);
    // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free
    assign w_top_idx = r_ptr_q - c_AW'(1);

    always_comb begin
        w_ptr_d    = r_ptr_q;
        w_count_d  = r_count_q;
        w_we       = 1'b0;
        w_waddr    = r_ptr_q;
        w_push_ovf = 1'b0;
        w_pop_unf  = 1'b0;
        case (stk_cmd_e'(commandIn))
            c_STK_PUSH: begin
                if (w_full) begin
                    w_push_ovf = 1'b1;
                    if (WRAP != 0) begin
                        w_we    = 1'b1;
                        w_ptr_d = r_ptr_q + c_AW'(1);
                    end
                end else begin
                    w_we      = 1'b1;
                    w_ptr_d   = r_ptr_q + c_AW'(1);
                    w_count_d = r_count_q + c_CW'(1);
                end
            end
            c_STK_POP: begin
                if (w_empty) begin
                    w_pop_unf = 1'b1;
                    if (WRAP != 0) begin
                        w_ptr_d = w_top_idx;
                    end
                end else begin
                    w_ptr_d   = w_top_idx;
                    w_count_d = r_count_q - c_CW'(1);
                end
            end
            c_STK_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_top_idx;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr_q   <= '0;
            r_count_q <= '0;
        end else begin
            r_ptr_q   <= w_ptr_d;
            r_count_q <= w_count_d;
        end
    end

    param_stack_file #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_file (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (in),
        .i_raddr (w_top_idx),
        .o_rdata (topOut)
    );

    assign countOut = r_count_q;
    assign fullOut  = w_full;
    assign emptyOut = w_empty;

`ifdef STACK_ERR_FLAGS_EN
    logic r_overflow_q,  w_overflow_d;
    logic r_underflow_q, w_underflow_d;

    // Clear wins over a same-cycle set
    always_comb begin
        w_overflow_d  = errClrIn ? 1'b0 : (r_overflow_q  | w_push_ovf);
        w_underflow_d = errClrIn ? 1'b0 : (r_underflow_q | w_pop_unf);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    assign overflowOut  = r_overflow_q;
    assign underflowOut = r_underflow_q;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{errClrIn, w_push_ovf, w_pop_unf};
    assign overflowOut    = 1'b0;
    assign underflowOut   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_stack.sv
//==============================================================================
// Module      : tb_param_stack
// Description : Scoreboard bench for param_stack: a DEPTH=4 saturating
//               instance and a DEPTH=2 wrapping instance share one stimulus
//               stream; a reference model predicts each cycle's outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_param_stack;

    localparam int c_W = 11;

    logic           clk;
    logic           rst_n;
    logic [1:0]     cmd;
    logic [c_W-1:0] din;
    logic           clr;

    logic [c_W-1:0] top0, top1;
    logic [2:0]     cnt0;
    logic [1:0]     cnt1;
    logic           full0, empty0, ovf0, unf0;
    logic           full1, empty1, ovf1, unf1;

    param_stack #(.WIDTH(c_W), .DEPTH(4), .WRAP(0)) u_dut0 (
        .clk(clk), .rst(rst_n), .commandIn(cmd), .in(din),
        .topOut(top0), .countOut(cnt0), .fullOut(full0), .emptyOut(empty0),
        .errClrIn(clr), .overflowOut(ovf0), .underflowOut(unf0)
    );

    param_stack #(.WIDTH(c_W), .DEPTH(2), .WRAP(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .commandIn(cmd), .in(din),
        .topOut(top1), .countOut(cnt1), .fullOut(full1), .emptyOut(empty1),
        .errClrIn(clr), .overflowOut(ovf1), .underflowOut(unf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [c_W-1:0] top;
        int             cnt;
        bit             full;
        bit             empty;
        bit             ovf;
        bit             unf;
    } exp_t;

    int             dep  [2] = '{4, 2};
    bit             wrp  [2] = '{1'b0, 1'b1};
    int             m_ptr[2];
    int             m_cnt[2];
    logic [c_W-1:0] m_mem[2][4];
    bit             m_ovf[2];
    bit             m_unf[2];

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_step(input int d, input logic [1:0] c,
                              input logic [c_W-1:0] v, input bit cl, input bit rn);
        bit set_o, set_u;
        set_o = 1'b0;
        set_u = 1'b0;
        if (!rn) begin
            m_ptr[d] = 0;
            m_cnt[d] = 0;
            for (int i = 0; i < 4; i++) m_mem[d][i] = '0;
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
        end else begin
            case (c)
                2'b01: begin
                    if (m_cnt[d] == dep[d]) set_o = 1'b1;
                    if (m_cnt[d] < dep[d] || wrp[d]) begin
                        m_mem[d][m_ptr[d]] = v;
                        m_ptr[d] = (m_ptr[d] + 1) % dep[d];
                    end
                    if (m_cnt[d] < dep[d]) m_cnt[d]++;
                end
                2'b10: begin
                    if (m_cnt[d] == 0) set_u = 1'b1;
                    if (m_cnt[d] > 0 || wrp[d]) m_ptr[d] = (m_ptr[d] + dep[d] - 1) % dep[d];
                    if (m_cnt[d] > 0) m_cnt[d]--;
                end
                2'b11: m_mem[d][(m_ptr[d] + dep[d] - 1) % dep[d]] = v;
                default: ;
            endcase
`ifdef STACK_ERR_FLAGS_EN
            m_ovf[d] = cl ? 1'b0 : (m_ovf[d] | set_o);
            m_unf[d] = cl ? 1'b0 : (m_unf[d] | set_u);
`else
            if (cl || set_o || set_u) begin
                m_ovf[d] = 1'b0;
                m_unf[d] = 1'b0;
            end
`endif
        end
    endtask

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.top   = m_mem[d][(m_ptr[d] + dep[d] - 1) % dep[d]];
        e.cnt   = m_cnt[d];
        e.full  = (m_cnt[d] == dep[d]);
        e.empty = (m_cnt[d] == 0);
        e.ovf   = m_ovf[d];
        e.unf   = m_unf[d];
        return e;
    endfunction

    // Drive on the falling edge; expectation describes state after next rising edge
    task automatic apply(input logic [1:0] c, input logic [c_W-1:0] v,
                         input bit cl, input bit rn);
        @(negedge clk);
        cmd   = c;
        din   = v;
        clr   = cl;
        rst_n = rn;
        model_step(0, c, v, cl, rn);
        model_step(1, c, v, cl, rn);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dut0.top",   int'(top0),   int'(e.top));
                check("dut0.count", int'(cnt0),   e.cnt);
                check("dut0.full",  int'(full0),  int'(e.full));
                check("dut0.empty", int'(empty0), int'(e.empty));
                check("dut0.ovf",   int'(ovf0),   int'(e.ovf));
                check("dut0.unf",   int'(unf0),   int'(e.unf));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1.top",   int'(top1),   int'(e.top));
                check("dut1.count", int'(cnt1),   e.cnt);
                check("dut1.full",  int'(full1),  int'(e.full));
                check("dut1.empty", int'(empty1), int'(e.empty));
                check("dut1.ovf",   int'(ovf1),   int'(e.ovf));
                check("dut1.unf",   int'(unf1),   int'(e.unf));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        cmd   = 2'b00;
        din   = '0;
        clr   = 1'b0;

        apply(2'b00, 11'h000, 1'b0, 1'b0);
        apply(2'b00, 11'h000, 1'b0, 1'b0);
        apply(2'b00, 11'h000, 1'b0, 1'b1);

        for (int i = 1; i <= 5; i++) apply(2'b01, 11'(11'h100 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply(2'b10, 11'h000, 1'b0, 1'b1);
        apply(2'b00, 11'h000, 1'b0, 1'b1);

        apply(2'b00, 11'h000, 1'b0, 1'b0);
        apply(2'b01, 11'h00A, 1'b0, 1'b1);
        apply(2'b01, 11'h00B, 1'b0, 1'b1);
        apply(2'b01, 11'h00C, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply(2'b10, 11'h000, 1'b0, 1'b1);

        apply(2'b00, 11'h000, 1'b0, 1'b0);
        apply(2'b01, 11'h055, 1'b0, 1'b1);
        apply(2'b11, 11'h1AA, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) apply(2'b01, 11'(11'h200 + i), 1'b0, 1'b1);
        apply(2'b01, 11'h2FF, 1'b1, 1'b1);
        apply(2'b00, 11'h000, 1'b0, 1'b1);

        apply(2'b00, 11'h000, 1'b0, 1'b0);
        apply(2'b01, 11'h011, 1'b0, 1'b1);
        apply(2'b01, 11'h022, 1'b0, 1'b0);
        apply(2'b00, 11'h000, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            apply(2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
        end

        apply(2'b00, 11'h000, 1'b0, 1'b1);
        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations never checked, expected 0", q0.size(), q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
